// File: rtl/mem_responder_pkg.sv
// Shared constants and types for the mem_responder memory slice.
package mem_responder_pkg;

    // RV32I funct3 size/sign codes for loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_t;

    // Stores only exist in byte, half and word flavours; the unsigned codes are load-only.
    function automatic logic store_size_ok(input logic [2:0] funct3);
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32I loads and stores: byte enables and shifted write word
// for stores, extracted and extended value for loads, and the alignment/legality flag.
module mem_lane_align
    import mem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdword,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_word,
    output logic [31:0] load_val,
    output logic        misalign
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Pick the addressed byte and half out of the stored word
    always_comb begin
        rd_byte = rdword[{addr_lo, 3'b000} +: 8];
        rd_half = addr_lo[1] ? rdword[31:16] : rdword[15:0];
    end

    // Decode size and alignment; an illegal access produces no enables and a zero load value
    always_comb begin
        byte_en  = 4'b0000;
        wr_word  = 32'h0000_0000;
        load_val = 32'h0000_0000;
        misalign = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en  = 4'b0001 << addr_lo;
                wr_word  = {4{wdata[7:0]}};
                load_val = {{24{rd_byte[7] & ~funct3[2]}}, rd_byte};
            end
            F3_H, F3_HU: begin
                if (addr_lo[0]) begin
                    misalign = 1'b1;
                end else begin
                    byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wr_word  = {2{wdata[15:0]}};
                    load_val = {{16{rd_half[15] & ~funct3[2]}}, rd_half};
                end
            end
            F3_W: begin
                if (addr_lo != 2'b00) begin
                    misalign = 1'b1;
                end else begin
                    byte_en  = 4'b1111;
                    wr_word  = wdata;
                    load_val = rdword;
                end
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Shared-RAM responder for the femtoRV32 fetch and load/store ports.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for a request; arbitrates and latches the winner
//   ST_WAIT | down-counting wait states; access happens when count is 0
//   ST_DONE | ready pulse for the served port, then back to idle
//
// last_grant doubles as the identity of the port being served while busy.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_misalign,
    output logic        busy
);

    localparam int WORDS = 2 ** (ADDR_W - 2);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    port_t             last_grant;
    logic              lat_we;
    logic [2:0]        lat_funct3;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;

    logic [31:0]       ram [WORDS];

    logic [31:0]       rd_word;
    logic [3:0]        byte_en;
    logic [31:0]       wr_word;
    logic [31:0]       load_val;
    logic              lane_err;
    logic              access_err;
    logic              access;
    logic              pick_data;
    logic              do_write;
    logic              unused_addr_hi;

    assign rd_word = ram[lat_addr[ADDR_W-1:2]];

    mem_lane_align u_lane_align (
        .funct3   (lat_funct3),
        .addr_lo  (lat_addr[1:0]),
        .wdata    (lat_wdata),
        .rdword   (rd_word),
        .byte_en  (byte_en),
        .wr_word  (wr_word),
        .load_val (load_val),
        .misalign (lane_err)
    );

    // Upper address bits fall outside the RAM and wrap away
    assign unused_addr_hi = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};

    // Access legality, terminal count, and round-robin pick (data wins a tie after a fetch)
    always_comb begin
        access_err = lane_err | (lat_we & ~store_size_ok(lat_funct3));
        access     = (state == ST_WAIT) && (cnt == '0);
        pick_data  = d_req && (!if_req || (last_grant == PORT_FETCH));
        do_write   = !rst && access && (last_grant == PORT_DATA) && lat_we && !access_err;
    end

    // RAM byte writes at the access edge; a reset on that same edge suppresses the write
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    ram[lat_addr[ADDR_W-1:2]][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    // Sequencing FSM with arbiter, wait counter, request latches and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            last_grant <= PORT_FETCH;
            lat_we     <= 1'b0;
            lat_funct3 <= F3_W;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            if_ready   <= 1'b0;
            if_rdata   <= '0;
            d_ready    <= 1'b0;
            d_rdata    <= '0;
            d_misalign <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            d_misalign <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (if_req || d_req) begin
                        busy  <= 1'b1;
                        cnt   <= CNT_LOAD;
                        state <= ST_WAIT;
                        if (pick_data) begin
                            last_grant <= PORT_DATA;
                            lat_we     <= d_we;
                            lat_funct3 <= d_funct3;
                            lat_addr   <= d_addr[ADDR_W-1:0];
                            lat_wdata  <= d_wdata;
                        end else begin
                            last_grant <= PORT_FETCH;
                            lat_we     <= 1'b0;
                            lat_funct3 <= F3_W;
                            lat_addr   <= if_addr[ADDR_W-1:0];
                            lat_wdata  <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= ST_DONE;
                        if (last_grant == PORT_DATA) begin
                            d_ready    <= 1'b1;
                            d_misalign <= access_err;
                            d_rdata    <= (access_err || lat_we) ? 32'h0000_0000 : load_val;
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= rd_word;
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
